// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared types for the registered control decoder.
// ALU op codes, opcodes, control bundle and pipe states.
package ctrl_decode_pipe_pkg;

  localparam logic [3:0] kADD   = 4'd0;
  localparam logic [3:0] kSUB   = 4'd1;
  localparam logic [3:0] kAND   = 4'd2;
  localparam logic [3:0] kNOT   = 4'd3;
  localparam logic [3:0] kBXOR  = 4'd4;
  localparam logic [3:0] kRXOR  = 4'd5;
  localparam logic [3:0] kSHIFT = 4'd6;
  localparam logic [3:0] kMOV   = 4'd7;
  localparam logic [3:0] kPASS  = 4'd8;

  localparam logic [2:0] OP_MEM   = 3'b000;
  localparam logic [2:0] OP_EQ    = 3'b001;
  localparam logic [2:0] OP_ARITH = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_MOV   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_SH    = 3'b110;
  localparam logic [2:0] OP_RXOR  = 3'b111;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_size;
    logic       func_ex;
    logic       jump;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    branch:    1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_size:  1'b1,
    func_ex:   1'b0,
    jump:      1'b0,
    alu_src:   1'b1,
    reg_write: 1'b1,
    alu_op:    kPASS
  };

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  function automatic logic is_mem(input ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational instruction to control-bundle decoder.
// Opcode is the top OPW bits, funct the low two bits.
module ctrl_decode_comb
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int IW  = 9,
  parameter int OPW = 3
) (
  input  logic [IW-1:0] instr,
  output ctrl_t         ctrl
);

  logic [OPW-1:0] op;
  logic [1:0]     funct;
  logic           unused_bits;

  assign op          = instr[IW-1 -: OPW];
  assign funct       = instr[1:0];
  assign unused_bits = ^instr;

  // Start from defaults and override per opcode/funct.
  always_comb begin
    ctrl = CTRL_DEFAULT;
    unique case (1'b1)
      op == OPW'(OP_MEM): begin
        unique case (funct)
          2'b00: begin
            ctrl.alu_op   = kADD;
            ctrl.mem_read = 1'b1;
            ctrl.alu_src  = 1'b0;
            ctrl.func_ex  = 1'b1;
          end
          2'b01: begin
            ctrl.alu_op    = kADD;
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b0;
            ctrl.func_ex   = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          2'b10: ctrl.alu_op = kNOT;
          default: begin
            ctrl.alu_op   = kBXOR;
            ctrl.reg_size = 1'b0;
          end
        endcase
      end
      op == OPW'(OP_EQ): begin
        ctrl.alu_op    = kSUB;
        ctrl.branch    = 1'b1;
        ctrl.reg_write = 1'b0;
      end
      op == OPW'(OP_ARITH): begin
        ctrl.alu_op   = funct[1] ? kSUB : kADD;
        ctrl.reg_size = 1'b0;
        ctrl.alu_src  = ~funct[0];
      end
      op == OPW'(OP_JAL): begin
        ctrl.alu_op = kPASS;
        ctrl.jump   = 1'b1;
      end
      op == OPW'(OP_MOV):  ctrl.alu_op = kMOV;
      op == OPW'(OP_AND):  ctrl.alu_op = kAND;
      op == OPW'(OP_SH): begin
        ctrl.alu_op  = kSHIFT;
        ctrl.alu_src = 1'b0;
      end
      op == OPW'(OP_RXOR): ctrl.alu_op = kRXOR;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered valid/ready control decoder with memory-wait stall and flush.
// Optional perf counters enabled by CTRL_PERF_CNT_EN.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int ALUW    = 4,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [IW-1:0]   Instr,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            RegSize,
  output logic            FuncEx,
  output logic            Jump,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [ALUW-1:0] ALUOp,
  output logic [CNTW-1:0] IssueCnt,
  output logic [CNTW-1:0] StallCnt
);

  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  ctrl_t          dec;
  ctrl_t          q;
  state_t         state;
  state_t         state_nx;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nx;
  logic           consume;
  logic           mem_done;
  logic           accept;

  ctrl_decode_comb #(
    .IW  (IW),
    .OPW (OPW)
  ) u_dec (
    .instr (Instr),
    .ctrl  (dec)
  );

  assign consume  = OutValid && OutReady;
  assign mem_done = consume && is_mem(q) && (MEM_LAT > 1);
  assign InReady  = !Flush && (state == RUN) &&
                    (!OutValid || (OutReady && !mem_done));
  assign accept   = InValid && InReady;

  // Memory-wait sequencing; flush abandons any wait.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      RUN: begin
        if (mem_done) begin
          state_nx = MEMWAIT;
          wcnt_nx  = WCW'(MEM_LAT - 1);
        end
      end
      MEMWAIT: begin
        if (wcnt <= WCW'(1)) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else begin
          wcnt_nx = wcnt - WCW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
    if (Flush) begin
      state_nx = RUN;
      wcnt_nx  = '0;
    end
  end

  // State, valid flag and held control bundle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= RUN;
      wcnt     <= '0;
      OutValid <= 1'b0;
      q        <= CTRL_DEFAULT;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (Flush) begin
        OutValid <= 1'b0;
      end else if (accept) begin
        OutValid <= 1'b1;
        q        <= dec;
      end else if (consume) begin
        OutValid <= 1'b0;
      end
    end
  end

  assign Branch   = q.branch;
  assign MemRead  = q.mem_read;
  assign MemWrite = q.mem_write;
  assign RegSize  = q.reg_size;
  assign FuncEx   = q.func_ex;
  assign Jump     = q.jump;
  assign ALUSrc   = q.alu_src;
  assign RegWrite = q.reg_write;
  assign ALUOp    = ALUW'(q.alu_op);

`ifdef CTRL_PERF_CNT_EN
  logic [CNTW-1:0] issue;
  logic [CNTW-1:0] stall;

  // Saturating issue and stall counters, untouched by flush.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      issue <= '0;
      stall <= '0;
    end else begin
      if (accept && (issue != '1))
        issue <= issue + CNTW'(1);
      if (InValid && !InReady && (stall != '1))
        stall <= stall + CNTW'(1);
    end
  end

  assign IssueCnt = issue;
  assign StallCnt = stall;
`else
  assign IssueCnt = '0;
  assign StallCnt = '0;
`endif

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Registered, handshaked successor to the combinational control decoder.
- Decodes one instruction per cycle into the standard control bundle and holds it in an output register under valid/ready back-pressure.
- Stalls the fetch side for a parametrised number of cycles after each memory op, and supports a flush from the branch/jump resolution logic.
- Sits between the instruction-memory fetch register and the register-file/ALU stage.

Parameters:
- IW, 9: instruction width. Opcode is instr[IW-1 -: OPW]; funct is instr[1:0]. IW must be >= OPW+2.
- OPW, 3: opcode field width. Only the default 3 is decoded; other values are reserved.
- ALUW, 4: ALUOp width, up to 16 ALU operations.
- MEM_LAT, 2: cycles a LOAD/STORE occupies memory. Must be >= 1.
- CNTW, 16: perf-counter width (optional feature only).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Flush  in  1  kill the held output and any memory wait.
- InValid  in  1  instruction present on Instr.
- InReady  out  1  block accepts Instr this cycle.
- Instr  in  IW  machine code.
- OutValid  out  1  control bundle valid.
- OutReady  in  1  downstream consumes bundle.
- Branch, MemRead, MemWrite, RegSize, FuncEx, Jump, ALUSrc, RegWrite  out  1 each  registered control bits.
- ALUOp  out  ALUW  registered ALU operation.
- IssueCnt  out  CNTW  accepted instructions (optional feature).
- StallCnt  out  CNTW  cycles with InValid=1 and InReady=0 (optional feature).

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State=RUN, OutValid=0.
  - Control bundle = defaults: Branch/MemRead/MemWrite/FuncEx/Jump=0; RegSize/ALUSrc/RegWrite=1; ALUOp=kPASS.
  - Counters=0. Reset mid-wait abandons the wait.
- Decode table (opcode/funct). Defaults apply unless listed:
  - 000/00 LOAD: kADD, MemRead, ALUSrc=0, FuncEx=1.
  - 000/01 STORE: kADD, MemWrite=1, ALUSrc=0, FuncEx=1, RegWrite=0.
  - 000/10 NOT: kNOT.
  - 000/11 BXOR: kBXOR, RegSize=0.
  - 001 EQ: kSUB, Branch, RegWrite=0.
  - 010 ADD/ADDI/SUB/SUBI (funct 00/01/10/11): kADD/kADD/kSUB/kSUB, RegSize=0; ALUSrc=0 for 01 and 11.
  - 011 JAL: kPASS, Jump.
  - 100 MOV: kMOV.
  - 101 AND: kAND.
  - 110 SH: kSHIFT, ALUSrc=0.
  - 111 RXOR: kRXOR.
- Latency: accepted instruction appears on outputs with OutValid=1 the next cycle.
- Handshake:
  - InReady = (state==RUN) && (!OutValid || OutReady).
  - Accept = InValid && InReady.
  - While OutValid && !OutReady, all outputs hold stable.
  - OutValid falls after a consume with no new accept.
  - Back-to-back accepts occur every cycle when OutReady=1.
- States:
  - RUN: normal issue.
  - MEMWAIT: entered on the cycle a LOAD/STORE bundle is consumed (OutValid && OutReady && (MemRead||MemWrite)), and only when MEM_LAT>1. A wait counter loads MEM_LAT-1; InReady=0; counter decrements each cycle; return to RUN when it reaches 1.
  - With MEM_LAT=1, MEMWAIT is never entered.
- Flush (synchronous, highest priority after reset):
  - OutValid<=0; state<=RUN; wait counter cleared.
  - InReady forced 0 in the Flush cycle, so no accept occurs and no instruction is lost silently.
- Simultaneous consume and accept: the new bundle replaces the old in the same edge.
- Simultaneous consume of a memory op and an InValid: not accepted, because InReady=0 is computed from the next state.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - IssueCnt increments on every accept.
  - StallCnt increments on every cycle with InValid && !InReady.
  - Both saturate at all-ones; neither is cleared by Flush.
- Undefined: counter logic absent; IssueCnt and StallCnt tied to 0.

Decomposition:
- Package definitions gains:
  - ALU op constants kADD=0, kSUB=1, kAND=2, kNOT=3, kBXOR=4, kRXOR=5, kSHIFT=6, kMOV=7, kPASS=8.
  - Opcode constants.
  - A packed struct ctrl_t holding the control bundle.
- One sub-module, ctrl_decode_comb: pure combinational instr→ctrl_t. The pipe instantiates it and registers its result.

Test Plan:
- Reset then ADD (9'b010_xxxx_00) with OutReady=1 → next cycle OutValid=1, ALUOp=0, RegSize=0, RegWrite=1, ALUSrc=1.
- Back-pressure: OutReady=0 for 3 cycles after SH → InReady=0, outputs hold kSHIFT/ALUSrc=0; OutReady=1 → next instruction accepted same edge.
- MEM_LAT=3, STORE then AND streamed → STORE bundle shows MemWrite=1/RegWrite=0; InReady low exactly 2 cycles after consume; AND issues afterwards.
- Flush asserted while OutValid=1 holding EQ and during MEMWAIT → OutValid=0 next cycle, InReady=1 the cycle after Flush drops.
- Reset_n pulsed low mid-MEMWAIT, asynchronously between edges → outputs return to defaults immediately, state RUN.
- With CTRL_PERF_CNT_EN, 10 accepts and 4 stalled cycles → IssueCnt=10, StallCnt=4; with CNTW=2 both saturate at 3.
